pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the five-stage MIPS datapath, the successor to the fixed-field ID/EX latch. It carries a generic data bundle (instruction, PC, operands, immediate) plus a control bundle between any two stages. It adds a valid/ready handshake, an optional skid buffer for full-throughput back-pressure, a synchronous flush that inserts a bubble, and a saturating stall counter. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-boundary widths.

---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush (bubble insert) and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam bit USE_SKID = (SKID != 32'sd0);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic valid_s;
  logic ready_s;
  logic accept_s;
  logic consume_s;

  assign valid_s   = (state_q != EMPTY);
  // Skid mode uses a registered ready so ready_i never reaches ready_o.
  assign ready_s   = USE_SKID ? ready_q : (!valid_s || ready_i);
  assign accept_s  = valid_i && ready_s;
  assign consume_s = valid_s && ready_i;

  // Next-state, datapath load selection and stall counter.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_i) begin
      state_d     = EMPTY;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            data_d  = data_i;
            ctrl_d  = ctrl_i;
            state_d = FULL;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Without a skid entry an accept in FULL always coincides with a consume.
          if (accept_s && (consume_s || !USE_SKID)) begin
            data_d  = data_i;
            ctrl_d  = ctrl_i;
            state_d = FULL;
          end else if (accept_s) begin
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
            state_d     = SKIDDED;
          end else if (consume_s) begin
            state_d = EMPTY;
          end else begin
            state_d = FULL;
          end
        end
        SKIDDED: begin
          if (consume_s) begin
            data_d  = skid_data_q;
            ctrl_d  = skid_ctrl_q;
            state_d = FULL;
          end else begin
            state_d = SKIDDED;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    ready_d = (state_d != SKIDDED);

    if (flush_i || !valid_s || ready_i) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, main/skid registers, registered ready and stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_o     = valid_s;
  assign ready_o     = ready_s;
  assign data_o      = data_q;
  // A bubble must never carry RegWrite/MemWrite/MemRead downstream.
  assign ctrl_o      = ctrl_q & {CTRL_W{valid_s}};
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid-mode instance (CNT_W=4) and one
// single-register instance, each with its own expected-output queue and monitor.
module tb_pipe_stage_reg;

  localparam int DW = 160;
  localparam int CW = 8;
  localparam int NW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_valid_i, a_ready_o, a_flush_i, a_valid_o, a_ready_i;
  logic [DW-1:0] a_data_i, a_data_o;
  logic [CW-1:0] a_ctrl_i, a_ctrl_o;
  logic [NW-1:0] a_stall_o;

  logic          b_valid_i, b_ready_o, b_flush_i, b_valid_o, b_ready_i;
  logic [DW-1:0] b_data_i, b_data_o;
  logic [CW-1:0] b_ctrl_i, b_ctrl_o;
  logic [7:0]    b_stall_o;

  item_t exp_a[$];
  item_t exp_b[$];
  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .ctrl_i(a_ctrl_i), .flush_i(a_flush_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .ctrl_o(a_ctrl_o), .stall_cnt_o(a_stall_o)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(8)) u_noskid (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .ctrl_i(b_ctrl_i), .flush_i(b_flush_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .ctrl_o(b_ctrl_o), .stall_cnt_o(b_stall_o)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input int d, input logic [CW-1:0] c, input bit push);
    item_t it;
    a_valid_i = v;
    a_data_i  = DW'(d);
    a_ctrl_i  = c;
    if (push) begin
      it.d = DW'(d);
      it.c = c;
      exp_a.push_back(it);
    end
  endtask

  task automatic drive_b(input bit v, input int d, input logic [CW-1:0] c, input bit push);
    item_t it;
    b_valid_i = v;
    b_data_i  = DW'(d);
    b_ctrl_i  = c;
    if (push) begin
      it.d = DW'(d);
      it.c = c;
      exp_b.push_back(it);
    end
  endtask

  // Monitor A: every consumed bundle must match the head of its queue.
  always @(negedge clk) begin
    item_t e;
    if (!rst && a_valid_o && a_ready_i) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: actual data=%0h ctrl=%0h, required no output", a_data_o, a_ctrl_o);
      end else begin
        e = exp_a.pop_front();
        chk("a_data", a_data_o, e.d);
        chk("a_ctrl", DW'(a_ctrl_o), DW'(e.c));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    item_t e;
    if (!rst && b_valid_o && b_ready_i) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: actual data=%0h ctrl=%0h, required no output", b_data_o, b_ctrl_o);
      end else begin
        e = exp_b.pop_front();
        chk("b_data", b_data_o, e.d);
        chk("b_ctrl", DW'(b_ctrl_o), DW'(e.c));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_flush_i = 1'b0; a_ready_i = 1'b0;
    b_flush_i = 1'b0; b_ready_i = 1'b0;
    drive_a(1'b0, 0, 8'h00, 1'b0);
    drive_b(1'b0, 0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", DW'(a_valid_o), DW'(1'b0));
    chk("rst_a_ready", DW'(a_ready_o), DW'(1'b1));
    chk("rst_a_ctrl", DW'(a_ctrl_o), DW'(8'h00));
    chk("rst_a_data", a_data_o, DW'(0));
    chk("rst_a_stall", DW'(a_stall_o), DW'(4'd0));
    chk("rst_b_ready", DW'(b_ready_o), DW'(1'b1));
    chk("rst_b_valid", DW'(b_valid_o), DW'(1'b0));
    rst = 1'b0;
    step();

    // Streaming: ten back-to-back bundles, no gaps.
    a_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, i, CW'(i + 1), 1'b1);
      step();
    end
    drive_a(1'b0, 0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("stream_drained", DW'(exp_a.size()), DW'(0));
    step();

    // Back-pressure: 100 in main, 101 in skid, 102 held upstream.
    a_ready_i = 1'b0;
    drive_a(1'b1, 100, 8'h10, 1'b1);
    step();
    chk("bp_ready_full", DW'(a_ready_o), DW'(1'b1));
    drive_a(1'b1, 101, 8'h11, 1'b1);
    step();
    chk("bp_ready_skid", DW'(a_ready_o), DW'(1'b0));
    chk("bp_hold_main", a_data_o, DW'(100));
    drive_a(1'b1, 102, 8'h12, 1'b0);
    step();
    chk("bp_ready_held", DW'(a_ready_o), DW'(1'b0));
    chk("bp_hold_main2", a_data_o, DW'(100));
    a_ready_i = 1'b1;
    step();
    chk("bp_skid_to_main", a_data_o, DW'(101));
    chk("bp_ready_back", DW'(a_ready_o), DW'(1'b1));
    drive_a(1'b1, 102, 8'h12, 1'b1);
    step();
    chk("bp_last", a_data_o, DW'(102));
    drive_a(1'b0, 0, 8'h00, 1'b0);
    step();
    chk("bp_empty", DW'(a_valid_o), DW'(1'b0));
    chk("bp_drained", DW'(exp_a.size()), DW'(0));

    // Flush concurrent with consume: 200 completes, 201 dropped.
    a_ready_i = 1'b0;
    drive_a(1'b1, 200, 8'hFF, 1'b1);
    step();
    chk("fl_ctrl_ff", DW'(a_ctrl_o), DW'(8'hFF));
    a_flush_i = 1'b1;
    a_ready_i = 1'b1;
    drive_a(1'b1, 201, 8'h77, 1'b0);
    step();
    a_flush_i = 1'b0;
    drive_a(1'b0, 0, 8'h00, 1'b0);
    chk("fl_valid", DW'(a_valid_o), DW'(1'b0));
    chk("fl_ctrl_zero", DW'(a_ctrl_o), DW'(8'h00));
    chk("fl_ready", DW'(a_ready_o), DW'(1'b1));

    // Flush from SKIDDED: 210, 211 and 212 are all discarded.
    a_ready_i = 1'b0;
    drive_a(1'b1, 210, 8'h21, 1'b0);
    step();
    drive_a(1'b1, 211, 8'h22, 1'b0);
    step();
    chk("fl2_skidded", DW'(a_ready_o), DW'(1'b0));
    a_flush_i = 1'b1;
    drive_a(1'b1, 212, 8'h24, 1'b0);
    step();
    a_flush_i = 1'b0;
    drive_a(1'b0, 0, 8'h00, 1'b0);
    chk("fl2_valid", DW'(a_valid_o), DW'(1'b0));
    chk("fl2_ready", DW'(a_ready_o), DW'(1'b1));
    a_ready_i = 1'b1;
    step();
    step();
    chk("fl2_no_replay", DW'(a_valid_o), DW'(1'b0));
    drive_a(1'b1, 220, 8'h23, 1'b1);
    step();
    drive_a(1'b0, 0, 8'h00, 1'b0);
    chk("fl2_after", a_data_o, DW'(220));
    step();

    // Stall counter saturates at 15, clears on consume.
    a_ready_i = 1'b0;
    drive_a(1'b1, 300, 8'h30, 1'b1);
    step();
    drive_a(1'b0, 0, 8'h00, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("stall_cnt", DW'(a_stall_o), DW'((j > 15) ? 15 : j));
    end
    a_ready_i = 1'b1;
    step();
    chk("stall_clear", DW'(a_stall_o), DW'(4'd0));
    chk("stall_empty", DW'(a_valid_o), DW'(1'b0));

    // Asynchronous reset mid-stream; bundle 400 is lost.
    a_ready_i = 1'b0;
    drive_a(1'b1, 400, 8'hA5, 1'b0);
    step();
    drive_a(1'b0, 0, 8'h00, 1'b0);
    step();
    chk("ar_ctrl_a5", DW'(a_ctrl_o), DW'(8'hA5));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", DW'(a_valid_o), DW'(1'b0));
    chk("ar_ctrl", DW'(a_ctrl_o), DW'(8'h00));
    chk("ar_data", a_data_o, DW'(0));
    chk("ar_stall", DW'(a_stall_o), DW'(4'd0));
    chk("ar_ready", DW'(a_ready_o), DW'(1'b1));
    step();
    rst = 1'b0;
    step();

    // Single-register mode: combinational ready and replace without bubble.
    b_ready_i = 1'b0;
    drive_b(1'b1, 500, 8'h11, 1'b1);
    step();
    chk("b_valid_full", DW'(b_valid_o), DW'(1'b1));
    chk("b_ready_low", DW'(b_ready_o), DW'(1'b0));
    b_ready_i = 1'b1;
    #1;
    chk("b_ready_comb", DW'(b_ready_o), DW'(1'b1));
    drive_b(1'b1, 501, 8'h22, 1'b1);
    step();
    chk("b_replace_valid", DW'(b_valid_o), DW'(1'b1));
    chk("b_replace_data", b_data_o, DW'(501));
    drive_b(1'b0, 0, 8'h00, 1'b0);
    step();
    chk("b_empty", DW'(b_valid_o), DW'(1'b0));
    step();

    chk("a_queue_empty", DW'(exp_a.size()), DW'(0));
    chk("b_queue_empty", DW'(exp_b.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
